// File: rtl/mac_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the MAC buffer-memory port between host, TX DMA and RX DMA.
// It watches acked transfers for descriptor-queue count pulses and aborts hung slave cycles.
module mac_wb_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 16,
  parameter int TMO_CYC = 255
) (
  input  logic             app_clk,
  input  logic             reset,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM*32-1:0] m_dat_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [3:0]       s_sel_o,
  output logic [31:0]      s_dat_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  input  logic [9:0]       cfg_tx_qbase_addr,
  input  logic [9:0]       cfg_rx_qbase_addr,
  output logic             tx_qcnt_inc,
  output logic             tx_qcnt_dec,
  output logic             rx_qcnt_inc,
  output logic             rx_qcnt_dec
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t        state_reg;
  logic [GW-1:0] grant_reg;
  logic [GW-1:0] last_grant_reg;
  logic [7:0]    tmo_cnt_reg;
  logic          tx_inc_reg;
  logic          tx_dec_reg;
  logic          rx_inc_reg;
  logic          rx_dec_reg;

  logic [AW-1:0] adr_arr [NM];
  logic [3:0]    sel_arr [NM];
  logic [31:0]   dat_arr [NM];

  logic          g_cyc;
  logic          g_stb;
  logic          g_we;
  logic          busy;
  logic          tmo_hit;
  logic          live;
  logic          ack_route;
  logic          snoop;
  logic          tx_hit;
  logic          rx_hit;
  logic [GW-1:0] rr_pick;
  logic          rr_found;

  for (genvar gi = 0; gi < NM; gi++) begin : g_master
    assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
    assign sel_arr[gi] = m_sel_i[gi*4 +: 4];
    assign dat_arr[gi] = m_dat_i[gi*32 +: 32];
    assign m_ack_o[gi] = ack_route & (grant_reg == GW'(gi));
    assign m_err_o[gi] = tmo_hit & (grant_reg == GW'(gi));
  end

  // Search starts just past the previous owner, so nobody keeps fixed priority.
  always_comb begin
    logic [GW-1:0] cand;
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NM; i++) begin
      cand = GW'((int'(last_grant_reg) + i) % NM);
      if (!rr_found && m_cyc_i[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign g_cyc = m_cyc_i[grant_reg];
  assign g_stb = m_stb_i[grant_reg];
  assign g_we  = m_we_i[grant_reg];

  // The owner's cyc drives the slave directly so a release drops s_cyc_o in the same cycle.
  assign busy      = (state_reg == BUSY);
  assign tmo_hit   = busy & g_cyc & (tmo_cnt_reg == 8'(TMO_CYC));
  assign live      = busy & g_cyc & ~tmo_hit;
  assign ack_route = live & g_stb & s_ack_i;

  assign s_cyc_o = live;
  assign s_stb_o = live & g_stb;
  assign s_we_o  = live & g_we;
  assign s_adr_o = live ? adr_arr[grant_reg] : '0;
  assign s_sel_o = live ? sel_arr[grant_reg] : '0;
  assign s_dat_o = live ? dat_arr[grant_reg] : '0;
  assign m_dat_o = live ? s_dat_i : '0;

  assign snoop  = s_cyc_o & s_stb_o & s_ack_i & s_sel_o[3];
  assign tx_hit = snoop & (s_adr_o[15:6] == cfg_tx_qbase_addr);
  assign rx_hit = snoop & (s_adr_o[15:6] == cfg_rx_qbase_addr);

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NM - 1);
      tmo_cnt_reg    <= '0;
      tx_inc_reg     <= 1'b0;
      tx_dec_reg     <= 1'b0;
      rx_inc_reg     <= 1'b0;
      rx_dec_reg     <= 1'b0;
    end else begin
      tx_inc_reg <= tx_hit & s_we_o;
      tx_dec_reg <= tx_hit & ~s_we_o;
      rx_inc_reg <= rx_hit & s_we_o;
      rx_dec_reg <= rx_hit & ~s_we_o;
      case (state_reg)
        IDLE: begin
          tmo_cnt_reg <= '0;
          if (rr_found) begin
            grant_reg <= rr_pick;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            last_grant_reg <= grant_reg;
            tmo_cnt_reg    <= '0;
            state_reg      <= IDLE;
          end else if (tmo_hit) begin
            tmo_cnt_reg <= '0;
            state_reg   <= ABORT;
          end else if (s_stb_o && !s_ack_i) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end else begin
            tmo_cnt_reg <= '0;
          end
        end
        ABORT: begin
          // Slave stays released until the aborted master gives up its cycle.
          tmo_cnt_reg <= '0;
          if (!g_cyc) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        default: begin
          tmo_cnt_reg <= '0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign tx_qcnt_inc = tx_inc_reg;
  assign tx_qcnt_dec = tx_dec_reg;
  assign rx_qcnt_inc = rx_inc_reg;
  assign rx_qcnt_dec = rx_dec_reg;

endmodule

// File: tb/tb_mac_wb_arbiter.sv
// Directed bench for mac_wb_arbiter: arbitration order, bursts, queue snoop, watchdog and reset.
module tb_mac_wb_arbiter;

  localparam int NM = 3;
  localparam int AW = 16;

  logic             app_clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM*32-1:0] m_dat_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [AW-1:0]    s_adr_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_dat_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic [9:0]       cfg_tx_qbase_addr;
  logic [9:0]       cfg_rx_qbase_addr;
  logic             tx_qcnt_inc;
  logic             tx_qcnt_dec;
  logic             rx_qcnt_inc;
  logic             rx_qcnt_dec;

  int checks   = 0;
  int failures = 0;

  logic [15:0] s1_adr [3];

  always #5 app_clk = ~app_clk;

  mac_wb_arbiter #(.NM(NM), .AW(AW), .TMO_CYC(255)) dut (
    .app_clk           (app_clk),
    .reset             (reset),
    .m_cyc_i           (m_cyc_i),
    .m_stb_i           (m_stb_i),
    .m_we_i            (m_we_i),
    .m_adr_i           (m_adr_i),
    .m_sel_i           (m_sel_i),
    .m_dat_i           (m_dat_i),
    .m_dat_o           (m_dat_o),
    .m_ack_o           (m_ack_o),
    .m_err_o           (m_err_o),
    .s_cyc_o           (s_cyc_o),
    .s_stb_o           (s_stb_o),
    .s_we_o            (s_we_o),
    .s_adr_o           (s_adr_o),
    .s_sel_o           (s_sel_o),
    .s_dat_o           (s_dat_o),
    .s_dat_i           (s_dat_i),
    .s_ack_i           (s_ack_i),
    .cfg_tx_qbase_addr (cfg_tx_qbase_addr),
    .cfg_rx_qbase_addr (cfg_rx_qbase_addr),
    .tx_qcnt_inc       (tx_qcnt_inc),
    .tx_qcnt_dec       (tx_qcnt_dec),
    .rx_qcnt_inc       (rx_qcnt_inc),
    .rx_qcnt_dec       (rx_qcnt_dec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge app_clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we, input logic [15:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = cyc;
    m_we_i[m]           = we;
    m_adr_i[m*AW +: AW] = adr;
    m_sel_i[m*4 +: 4]   = sel;
    m_dat_i[m*32 +: 32] = dat;
  endtask

  function automatic logic [31:0] q4();
    return {28'd0, tx_qcnt_inc, tx_qcnt_dec, rx_qcnt_inc, rx_qcnt_dec};
  endfunction

  initial begin
    int early;
    s1_adr[0] = 16'h0100;
    s1_adr[1] = 16'h0200;
    s1_adr[2] = 16'h0300;
    reset = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;
    cfg_tx_qbase_addr = 10'h3FF;
    cfg_rx_qbase_addr = 10'h3FE;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_ack", 32'(m_ack_o), 32'd0);
    check("rst_err", 32'(m_err_o), 32'd0);
    check("rst_q", q4(), 32'd0);

    // All three request together; each drops after one ack.
    step();
    for (int m = 0; m < 3; m++) set_m(m, 1'b1, 1'b0, s1_adr[m], 4'hF, 32'd0);
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_0000;
    #1;
    check("s1_arb_lat", 32'(s_cyc_o), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("s1_cyc", 32'(s_cyc_o), 32'd1);
      check("s1_adr", 32'(s_adr_o), 32'(s1_adr[k]));
      check("s1_ack", 32'(m_ack_o), 32'(1 << k));
      $display("txn rr grant m%0d adr=%h ack=%b", k, s_adr_o, m_ack_o);
      step();
      set_m(k, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
      #1;
      check("s1_drop_cyc", 32'(s_cyc_o), 32'd0);
      check("s1_drop_ack", 32'(m_ack_o), 32'd0);
      step();
      #1;
      check("s1_gap", 32'(s_cyc_o), 32'd0);
      step();
    end
    s_ack_i = 1'b0;

    // M1 burst of four reads, ack every cycle.
    set_m(1, 1'b1, 1'b0, 16'h0400, 4'hF, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1;
      s_dat_i = 32'hA5A5_0000 + 32'(i);
      #1;
      check("s2_ack", 32'(m_ack_o), 32'b010);
      check("s2_dat", m_dat_o, 32'hA5A5_0000 + 32'(i));
      $display("txn burst m1 beat %0d dat=%h", i, m_dat_o);
      step();
    end
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("s2_end_cyc", 32'(s_cyc_o), 32'd0);
    step();

    // M2 write into the RX queue window: sel[3] set pulses, sel[3] clear does not.
    cfg_tx_qbase_addr = 10'h3FF;
    cfg_rx_qbase_addr = 10'h049;
    set_m(2, 1'b1, 1'b1, 16'h1240, 4'b1000, 32'hDEAD_BEEF);
    step();
    s_ack_i = 1'b1;
    #1;
    check("s3_ack", 32'(m_ack_o), 32'b100);
    check("s3_wdat", s_dat_o, 32'hDEAD_BEEF);
    check("s3_q_early", q4(), 32'd0);
    $display("txn write m2 adr=%h sel=%b", s_adr_o, s_sel_o);
    step();
    set_m(2, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("s3_rx_inc", q4(), 32'b0010);
    step();
    #1;
    check("s3_pulse_end", q4(), 32'd0);
    set_m(2, 1'b1, 1'b1, 16'h1240, 4'b0111, 32'h0BAD_F00D);
    step();
    s_ack_i = 1'b1;
    #1;
    check("s3b_ack", 32'(m_ack_o), 32'b100);
    $display("txn write m2 adr=%h sel=%b", s_adr_o, s_sel_o);
    step();
    set_m(2, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("s3b_no_pulse", q4(), 32'd0);
    step();

    // M0 stalls: 255 cycles without ack, then the abort cycle.
    set_m(0, 1'b1, 1'b0, 16'h0040, 4'hF, 32'd0);
    step();
    early = 0;
    for (int i = 0; i < 255; i++) begin
      #1;
      if (!s_cyc_o || m_err_o != 3'b000) early++;
      step();
    end
    #1;
    check("s4_stall", 32'(early), 32'd0);
    check("s4_err", 32'(m_err_o), 32'b001);
    check("s4_abort_cyc", 32'(s_cyc_o), 32'd0);
    $display("txn watchdog abort m0 err=%b", m_err_o);
    step();
    s_ack_i = 1'b1;
    #1;
    check("s4_err_once", 32'(m_err_o), 32'd0);
    check("s4_hold_cyc", 32'(s_cyc_o), 32'd0);
    check("s4_late_ack", 32'(m_ack_o), 32'd0);
    step();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    step();
    #1;
    check("s4_idle", 32'(s_cyc_o), 32'd0);

    // Reset in the middle of an M1 burst that hits the TX queue window.
    cfg_tx_qbase_addr = 10'h010;
    set_m(1, 1'b1, 1'b0, 16'h0400, 4'hF, 32'd0);
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'h5555_AAAA;
    #1;
    check("s5_ack", 32'(m_ack_o), 32'b010);
    step();
    reset = 1'b1;
    step();
    #1;
    check("s5_rst_cyc", 32'(s_cyc_o), 32'd0);
    check("s5_rst_ack", 32'(m_ack_o), 32'd0);
    check("s5_rst_dat", m_dat_o, 32'd0);
    check("s5_rst_q", q4(), 32'd0);
    $display("txn reset mid-burst m1");
    reset = 1'b0;
    cfg_tx_qbase_addr = 10'h022;
    cfg_rx_qbase_addr = 10'h022;
    set_m(0, 1'b1, 1'b0, 16'h0880, 4'hF, 32'd0);
    step();
    #1;
    check("s5_m0_first", 32'(s_adr_o), 32'h0880);
    check("s6_ack", 32'(m_ack_o), 32'b001);
    $display("txn post-reset grant adr=%h", s_adr_o);

    // Equal TX/RX bases on a read ack: both decrements pulse together.
    step();
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("s6_both_dec", q4(), 32'b0101);
    step();
    #1;
    check("s6_pulse_end", q4(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
